// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, functs, FSM states,
// ALU operations, write-back selects and the decoded instruction class.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluSub = 2'd1,
    AluXor = 2'd2,
    AluSlt = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    WbAlu = 2'd0,
    WbMem = 2'd1,
    WbPc4 = 2'd2
  } wb_sel_e;

  typedef enum logic [3:0] {
    ClsIllegal,
    ClsRArith,
    ClsJr,
    ClsLw,
    ClsSw,
    ClsJ,
    ClsJal,
    ClsBeq,
    ClsBne,
    ClsIArith
  } instr_cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct to instruction class plus the
// ALU operation and operand select used by the control FSM.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] cls_o,
  output logic [1:0] alu_op_o,
  output logic       alu_src_o
);

  instr_cls_e cls;
  alu_op_e    alu_op;
  logic       alu_src;

  always_comb begin
    cls     = ClsIllegal;
    alu_op  = AluAdd;
    alu_src = 1'b0;
    case (op_i)
      OpRtype: begin
        case (funct_i)
          FnAdd: cls = ClsRArith;
          FnSub: begin
            cls    = ClsRArith;
            alu_op = AluSub;
          end
          FnSlt: begin
            cls    = ClsRArith;
            alu_op = AluSlt;
          end
          FnJr:    cls = ClsJr;
          default: cls = ClsIllegal;
        endcase
      end
      OpLw: begin
        cls     = ClsLw;
        alu_src = 1'b1;
      end
      OpSw: begin
        cls     = ClsSw;
        alu_src = 1'b1;
      end
      OpJ:   cls = ClsJ;
      OpJal: cls = ClsJal;
      OpBeq: begin
        cls    = ClsBeq;
        alu_op = AluSub;
      end
      OpBne: begin
        cls    = ClsBne;
        alu_op = AluSub;
      end
      OpAddi: begin
        cls     = ClsIArith;
        alu_src = 1'b1;
      end
      // Immediate is zero-extended for XORI; the datapath keys that off alu_op.
      OpXori: begin
        cls     = ClsIArith;
        alu_op  = AluXor;
        alu_src = 1'b1;
      end
      default: cls = ClsIllegal;
    endcase
  end

  assign cls_o     = cls;
  assign alu_op_o  = alu_op;
  assign alu_src_o = alu_src;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) driving fetch PC update and datapath.
// Define ILLEGAL_HALT_EN to halt on unsupported instructions; otherwise they retire as NOPs.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned RA_REG     = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           instr,
  input  logic [31:0]           pc,
  input  logic [31:0]           rs_data,
  input  logic                  alu_zero,
  output logic                  write_pc,
  output logic                  is_branch,
  output logic                  is_jump,
  output logic [15:0]           branch_addr,
  output logic [31:0]           jump_addr,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic [REG_ADDR_W-1:0] rt_addr,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  alu_src,
  output logic [1:0]            alu_op,
  output logic                  mem_we,
  output logic                  illegal
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  dec_cls;
  logic [1:0]  dec_alu_op;
  logic        dec_alu_src;
  instr_cls_e  cls;

  // Only the region bits of the PC form part of a J/JAL target.
  logic        unused_pc;
  assign unused_pc = ^pc[27:0];

  ctrl_decode u_decode (
    .op_i      (ir_q[31:26]),
    .funct_i   (ir_q[5:0]),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src)
  );

  assign cls         = instr_cls_e'(dec_cls);
  assign rs_addr     = REG_ADDR_W'(ir_q[25:21]);
  assign rt_addr     = REG_ADDR_W'(ir_q[20:16]);
  assign branch_addr = ir_q[15:0];
  assign illegal     = illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    write_pc  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    jump_addr = '0;
    wr_addr   = '0;
    reg_we    = 1'b0;
    wb_sel    = WbAlu;
    alu_src   = 1'b0;
    alu_op    = AluAdd;
    mem_we    = 1'b0;

    unique case (state_q)
      StFetch: begin
        ir_d    = instr;
        state_d = StDecode;
      end
      StDecode: begin
        if (cls == ClsIllegal) begin
`ifdef ILLEGAL_HALT_EN
          illegal_d = 1'b1;
          state_d   = StHalt;
`else
          state_d   = StWb;
`endif
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        case (cls)
          ClsBeq, ClsBne: begin
            write_pc  = 1'b1;
            is_branch = (cls == ClsBeq) ? alu_zero : !alu_zero;
            state_d   = StFetch;
          end
          ClsJ, ClsJal: begin
            write_pc  = 1'b1;
            is_jump   = 1'b1;
            jump_addr = {pc[31:28], ir_q[25:0], 2'b00};
            state_d   = StFetch;
            // JAL links in the same cycle the jump retires.
            if (cls == ClsJal) begin
              reg_we  = 1'b1;
              wr_addr = REG_ADDR_W'(RA_REG);
              wb_sel  = WbPc4;
            end
          end
          ClsJr: begin
            write_pc  = 1'b1;
            is_jump   = 1'b1;
            jump_addr = rs_data;
            state_d   = StFetch;
          end
          ClsLw, ClsSw: state_d = StMem;
          default:      state_d = StWb;
        endcase
      end
      StMem: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        if (cls == ClsSw) begin
          mem_we   = 1'b1;
          write_pc = 1'b1;
          state_d  = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StWb: begin
        alu_op   = dec_alu_op;
        alu_src  = dec_alu_src;
        write_pc = 1'b1;
        state_d  = StFetch;
        // An unsupported instruction reaching WB is a NOP: advance PC, no write.
        if (cls != ClsIllegal) begin
          reg_we  = 1'b1;
          wb_sel  = (cls == ClsLw) ? WbMem : WbAlu;
          wr_addr = (cls == ClsRArith) ? REG_ADDR_W'(ir_q[15:11]) : REG_ADDR_W'(ir_q[20:16]);
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of directed instructions plus
// hand-written reset-abort and illegal-opcode sequences.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs_data;
  logic        alu_zero;
  logic        write_pc;
  logic        is_branch;
  logic        is_jump;
  logic [15:0] branch_addr;
  logic [31:0] jump_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wr_addr;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        mem_we;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl #(
    .REG_ADDR_W (5),
    .RA_REG     (31)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr       (instr),
    .pc          (pc),
    .rs_data     (rs_data),
    .alu_zero    (alu_zero),
    .write_pc    (write_pc),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .wr_addr     (wr_addr),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .mem_we      (mem_we),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs;
    logic        zero;
    int          cpi;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [15:0] baddr;
    logic        chk_alu;
    logic [1:0]  aop;
    logic        asrc;
    logic        br;
    logic        jmp;
    logic [31:0] jaddr;
    logic        rwe;
    logic [4:0]  wr;
    logic [1:0]  wb;
    int          n_mem;
    int          n_reg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] ins, input logic [31:0] p,
                              input logic [31:0] rs, input logic z, input int cpi,
                              input logic [4:0] rs_a, input logic [4:0] rt_a,
                              input logic [15:0] baddr, input logic chk_alu,
                              input logic [1:0] aop, input logic asrc, input logic br,
                              input logic jmp, input logic [31:0] jaddr, input logic rwe,
                              input logic [4:0] wr, input logic [1:0] wb, input int n_mem,
                              input int n_reg);
    vec_t v;
    v.name = name;   v.instr = ins;     v.pc = p;       v.rs = rs;     v.zero = z;
    v.cpi = cpi;     v.rs_a = rs_a;     v.rt_a = rt_a;  v.baddr = baddr;
    v.chk_alu = chk_alu; v.aop = aop;   v.asrc = asrc;  v.br = br;     v.jmp = jmp;
    v.jaddr = jaddr; v.rwe = rwe;       v.wr = wr;      v.wb = wb;
    v.n_mem = n_mem; v.n_reg = n_reg;
    return v;
  endfunction

  // Entered at a falling edge with the DUT in FETCH; leaves with the DUT back in FETCH.
  task automatic run_vec(input vec_t v);
    int          cyc = 0;
    int          n_wpc = 0;
    int          n_mem = 0;
    int          n_reg = 0;
    logic        ill_seen = 1'b0;
    logic [4:0]  s_rs = '0, s_rt = '0, s_wr = '0;
    logic [1:0]  s_aop = '0, s_wb = '0;
    logic        s_asrc = 1'b0, s_br = 1'b0, s_jmp = 1'b0, s_rwe = 1'b0;
    logic [31:0] s_ja = '0;
    logic [15:0] s_ba = '0;
    instr    = v.instr;
    pc       = v.pc;
    rs_data  = v.rs;
    alu_zero = v.zero;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (write_pc) n_wpc++;
      if (mem_we)   n_mem++;
      if (reg_we)   n_reg++;
      if (illegal)  ill_seen = 1'b1;
      if (c == 2) begin
        s_rs = rs_addr;
        s_rt = rt_addr;
      end
      if (c == 3) begin
        s_aop  = alu_op;
        s_asrc = alu_src;
      end
      if (write_pc) begin
        cyc   = c;
        s_br  = is_branch;
        s_jmp = is_jump;
        s_ja  = jump_addr;
        s_rwe = reg_we;
        s_wr  = wr_addr;
        s_wb  = wb_sel;
        s_ba  = branch_addr;
        break;
      end
      @(negedge clk);
    end
    check({v.name, ".cpi"}, cyc, v.cpi);
    check({v.name, ".rs_addr"}, s_rs, v.rs_a);
    check({v.name, ".rt_addr"}, s_rt, v.rt_a);
    if (v.chk_alu) begin
      check({v.name, ".alu_op"}, s_aop, v.aop);
      check({v.name, ".alu_src"}, s_asrc, v.asrc);
    end
    check({v.name, ".is_branch"}, s_br, v.br);
    check({v.name, ".is_jump"}, s_jmp, v.jmp);
    check({v.name, ".jump_addr"}, s_ja, v.jaddr);
    check({v.name, ".reg_we"}, s_rwe, v.rwe);
    check({v.name, ".wr_addr"}, s_wr, v.wr);
    check({v.name, ".wb_sel"}, s_wb, v.wb);
    check({v.name, ".branch_addr"}, s_ba, v.baddr);
    check({v.name, ".mem_we_count"}, n_mem, v.n_mem);
    check({v.name, ".reg_we_count"}, n_reg, v.n_reg);
    check({v.name, ".illegal"}, ill_seen, 1'b0);
    @(negedge clk);
    #1;
    check({v.name, ".next_fetch_quiet"}, {write_pc, reg_we, mem_we, is_jump, is_branch}, 5'b0);
  endtask

  initial begin
    //          name        instr         pc            rs_data       z cpi rs  rt  baddr  chk op   src br jmp jaddr         rwe wr  wb mem reg
    vecs.push_back(mk("add",    32'h00221820, 32'h0, 32'h0, 0, 4, 1, 2, 16'h1820, 1, 2'd0, 0, 0, 0, 32'h0, 1, 3, 2'd0, 0, 1));
    vecs.push_back(mk("sub",    32'h00A62022, 32'h0, 32'h0, 0, 4, 5, 6, 16'h2022, 1, 2'd1, 0, 0, 0, 32'h0, 1, 4, 2'd0, 0, 1));
    vecs.push_back(mk("slt",    32'h0109382A, 32'h0, 32'h0, 0, 4, 8, 9, 16'h382A, 1, 2'd3, 0, 0, 0, 32'h0, 1, 7, 2'd0, 0, 1));
    vecs.push_back(mk("addi",   32'h216A0005, 32'h0, 32'h0, 0, 4, 11, 10, 16'h0005, 1, 2'd0, 1, 0, 0, 32'h0, 1, 10, 2'd0, 0, 1));
    vecs.push_back(mk("xori",   32'h39ACFFFF, 32'h0, 32'h0, 0, 4, 13, 12, 16'hFFFF, 1, 2'd2, 1, 0, 0, 32'h0, 1, 12, 2'd0, 0, 1));
    vecs.push_back(mk("lw",     32'h8C250008, 32'h0, 32'h0, 0, 5, 1, 5, 16'h0008, 1, 2'd0, 1, 0, 0, 32'h0, 1, 5, 2'd1, 0, 1));
    vecs.push_back(mk("sw",     32'hAC46000C, 32'h0, 32'h0, 0, 4, 2, 6, 16'h000C, 1, 2'd0, 1, 0, 0, 32'h0, 0, 0, 2'd0, 1, 0));
    vecs.push_back(mk("beq_t",  32'h10220004, 32'h0, 32'h0, 1, 3, 1, 2, 16'h0004, 1, 2'd1, 0, 1, 0, 32'h0, 0, 0, 2'd0, 0, 0));
    vecs.push_back(mk("beq_nt", 32'h10220004, 32'h0, 32'h0, 0, 3, 1, 2, 16'h0004, 1, 2'd1, 0, 0, 0, 32'h0, 0, 0, 2'd0, 0, 0));
    vecs.push_back(mk("bne_t",  32'h1464FFFE, 32'h0, 32'h0, 0, 3, 3, 4, 16'hFFFE, 1, 2'd1, 0, 1, 0, 32'h0, 0, 0, 2'd0, 0, 0));
    vecs.push_back(mk("bne_nt", 32'h1464FFFE, 32'h0, 32'h0, 1, 3, 3, 4, 16'hFFFE, 1, 2'd1, 0, 0, 0, 32'h0, 0, 0, 2'd0, 0, 0));
    vecs.push_back(mk("j",      32'h08000100, 32'h90000000, 32'h0, 0, 3, 0, 0, 16'h0100, 1, 2'd0, 0, 0, 1, 32'h90000400, 0, 0, 2'd0, 0, 0));
    vecs.push_back(mk("jal",    32'h0C000010, 32'h40000000, 32'h0, 0, 3, 0, 0, 16'h0010, 1, 2'd0, 0, 0, 1, 32'h40000040, 1, 31, 2'd2, 0, 1));
    vecs.push_back(mk("jr",     32'h03E00008, 32'h0, 32'h00000123, 0, 3, 31, 0, 16'h0008, 1, 2'd0, 0, 0, 1, 32'h00000123, 0, 0, 2'd0, 0, 0));
`ifndef ILLEGAL_HALT_EN
    vecs.push_back(mk("nop_op", 32'hFC000000, 32'h0, 32'h0, 0, 3, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 0, 32'h0, 0, 0, 2'd0, 0, 0));
    vecs.push_back(mk("nop_fn", 32'h00221800, 32'h0, 32'h0, 0, 3, 1, 2, 16'h1800, 0, 2'd0, 0, 0, 0, 32'h0, 0, 0, 2'd0, 0, 0));
`endif

    reset_n  = 1'b0;
    instr    = '0;
    pc       = '0;
    rs_data  = '0;
    alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.ctrl", {write_pc, is_branch, is_jump, reg_we, mem_we, alu_src, illegal, wb_sel,
                         alu_op}, 11'b0);
    check("reset.jump_addr", jump_addr, 32'h0);
    check("reset.addrs", {rs_addr, rt_addr, wr_addr, branch_addr}, 31'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while SW sits in MEM: the store and PC update must be abandoned.
    instr = 32'hAC46000C;
    repeat (3) @(negedge clk);
    #1;
    check("sw_abort.pre_mem_we", mem_we, 1'b1);
    reset_n = 1'b0;
    #1;
    check("sw_abort.mem_we", mem_we, 1'b0);
    check("sw_abort.write_pc", write_pc, 1'b0);
    @(posedge clk);
    #1;
    check("sw_abort.held", {mem_we, write_pc, reg_we}, 3'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(vecs[0]);

`ifdef ILLEGAL_HALT_EN
    begin
      int n_wpc = 0;
      int n_en  = 0;
      instr = 32'hFC000000;
      for (int c = 1; c <= 8; c++) begin
        #1;
        if (write_pc) n_wpc++;
        if (reg_we || mem_we) n_en++;
        @(negedge clk);
      end
      #1;
      check("halt.illegal", illegal, 1'b1);
      check("halt.write_pc_count", n_wpc, 0);
      check("halt.enables", n_en, 0);
      reset_n = 1'b0;
      #1;
      check("halt.reset_clears", illegal, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      run_vec(vecs[0]);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
